// File: rtl/pgm_pkg.sv
// Shared types and constants for the PGM sprite A-ROM fetch path.
// The request struct is sized for the default 29-bit address / 5-bit slot tag.
package pgm_pkg;

   localparam int AROM_WORD_BITS = 64;
   localparam int AROM_ADDR_W    = 29;
   localparam int AROM_TAG_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arom_state_e;

   typedef struct packed {
      logic [AROM_ADDR_W-1:0] addr;
      logic [AROM_TAG_W-1:0]  tag;
   } arom_req_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pgm_arom_cache.sv
// Small fully associative A-ROM word cache: combinational lookup, first-invalid
// victim choice falling back to a round-robin pointer once every line is valid.
module pgm_arom_cache
   import pgm_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int ADDR_W  = 29
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [ADDR_W-1:0]         lookup_addr,
   output logic                      hit,
   output logic [AROM_WORD_BITS-1:0] hit_data,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [AROM_WORD_BITS-1:0] wr_data
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [ADDR_W-1:0]         tag_q  [ENTRIES];
   logic [AROM_WORD_BITS-1:0] data_q [ENTRIES];
   logic [ENTRIES-1:0]        valid_q;
   logic [IDX_W-1:0]          ptr_q;
   logic [IDX_W-1:0]          victim;
   logic                      all_valid;

   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[i];
         end
      end
   end

   // Scanning downwards leaves the lowest-indexed invalid line as the victim.
   always_comb begin
      all_valid = &valid_q;
      victim    = ptr_q;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         ptr_q   <= '0;
      end else if (flush) begin
         valid_q <= '0;
         ptr_q   <= '0;
      end else if (wr_en) begin
         valid_q[victim] <= 1'b1;
         if (all_valid) ptr_q <= ptr_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         tag_q[victim]  <= wr_addr;
         data_q[victim] <= wr_data;
      end
   end

endmodule

// File: rtl/pgm_arom_fetch.sv
// Sprite A-ROM fetch unit: serves 64-bit word requests from a small cache and
// issues one single-beat DDRAM read at a time on a miss.
module pgm_arom_fetch
   import pgm_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int ADDR_W  = 29,
   parameter int TAG_W   = 5
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [TAG_W-1:0]          req_tag,
   output logic                      rsp_valid,
   output logic [AROM_WORD_BITS-1:0] rsp_data,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      rsp_hit,
   output logic                      ddram_rd,
   output logic [ADDR_W-1:0]         ddram_addr,
   input  logic                      ddram_busy,
   input  logic [AROM_WORD_BITS-1:0] ddram_dout,
   input  logic                      ddram_dout_ready,
   output logic [15:0]               hit_cnt,
   output logic [15:0]               miss_cnt,
   output arom_state_e               state_dbg
);

   // Handshake: a request transfers on any cycle with req_valid && req_ready;
   // the response is a single rsp_valid pulse with no backpressure.
   arom_state_e               state_q, state_d;
   arom_req_t                 req_q;
   logic                      live_q;
   logic                      flushed_q;
   logic                      accept;
   logic                      cache_hit;
   logic                      lookup_hit;
   logic                      cache_wr;
   logic [AROM_WORD_BITS-1:0] cache_data;

   assign accept     = req_valid && req_ready;
   assign lookup_hit = cache_hit && !flush;
   assign cache_wr   = (state_q == ST_WAIT) && ddram_dout_ready && !flushed_q;
   assign ddram_addr = req_q.addr;
   assign state_dbg  = state_q;

   pgm_arom_cache #(
      .ENTRIES (ENTRIES),
      .ADDR_W  (ADDR_W)
   ) u_cache (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .lookup_addr (req_addr),
      .hit         (cache_hit),
      .hit_data    (cache_data),
      .wr_en       (cache_wr),
      .wr_addr     (req_q.addr),
      .wr_data     (ddram_dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && !lookup_hit) state_d = ST_ISSUE;
         ST_ISSUE: if (!ddram_busy)           state_d = ST_WAIT;
         ST_WAIT:  if (ddram_dout_ready)      state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   // live_q holds req_ready low until the first clock after reset release.
   always_comb begin
      req_ready = (state_q == ST_IDLE) && live_q;
      ddram_rd  = (state_q == ST_ISSUE) && !ddram_busy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live_q    <= 1'b0;
         req_q     <= '0;
         flushed_q <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
      end else begin
         live_q    <= 1'b1;
         rsp_valid <= 1'b0;
         if (accept) begin
            if (lookup_hit) begin
               rsp_valid <= 1'b1;
               rsp_hit   <= 1'b1;
               rsp_tag   <= req_tag;
               rsp_data  <= cache_data;
            end else begin
               req_q.addr <= req_addr;
               req_q.tag  <= req_tag;
               flushed_q  <= 1'b0;
            end
         end else if (flush && (state_q != ST_IDLE)) begin
            // The read in flight still completes but must not repopulate the cache.
            flushed_q <= 1'b1;
         end
         if ((state_q == ST_WAIT) && ddram_dout_ready) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_tag   <= req_q.tag;
            rsp_data  <= ddram_dout;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (flush) begin
         hit_cnt  <= '0;
         miss_cnt <= accept ? 16'd1 : 16'd0;
      end else if (accept) begin
         if (cache_hit) hit_cnt  <= sat_inc16(hit_cnt);
         else           miss_cnt <= sat_inc16(miss_cnt);
      end
   end

endmodule
